// File: rtl/byte_serial_adder.sv
// Multi-byte serial adder: one byte pair per beat, LSB first, through a
// conditional-sum byte adder, with the packed result held on a valid/ready port.

module conditional_sum_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    // Upper nibble is precomputed for both carries; the lower nibble carry selects.
    assign lo   = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0, cin};
    assign hi0  = {1'b0, x[7:4]} + {1'b0, y[7:4]};
    assign hi1  = hi0 + 5'd1;
    assign s    = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    assign cout = lo[4] ? hi1[4] : hi0[4];
endmodule

// state | meaning
// ACC   | accepting operand beats, cnt = index of the next byte
// HOLD  | result presented on out_*, waiting for out_ready
module byte_serial_adder #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_x,
    input  logic [7:0]          in_y,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_sum,
    output logic                out_cout,
    output logic                out_ovf
);
    localparam int CW = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          carry_q;
    logic          cin_sel;
    logic [7:0]    s;
    logic          c;
    logic          xfer;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign xfer      = in_valid && in_ready;
    assign cin_sel   = (cnt == '0) ? in_cin : carry_q;

    conditional_sum_adder u_csa (
        .x    (in_x),
        .y    (in_y),
        .cin  (cin_sel),
        .s    (s),
        .cout (c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            cnt      <= '0;
            carry_q  <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (xfer) begin
                        for (int k = 0; k < NBYTES; k++) begin
                            if (cnt == k[CW-1:0]) out_sum[k*8 +: 8] <= s;
                        end
                        carry_q <= c;
                        if (cnt == LAST) begin
                            cnt      <= '0;
                            state    <= HOLD;
                            out_cout <= c;
                            out_ovf  <= (in_x[7] == in_y[7]) && (s[7] != in_x[7]);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) state <= ACC;
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed bench for byte_serial_adder (NBYTES=4) with an expected-result queue.

module tb_byte_serial_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    byte_serial_adder #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic drive_beat(input logic [7:0] x, input logic [7:0] y, input logic ci);
        int n = 0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_cin = ci;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("beat_accept_timeout", 64'(n < 20), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_x = 8'($urandom);
        in_y = 8'($urandom);
        in_cin = 1'($urandom);
    endtask

    task automatic send_op(input logic [31:0] x, input logic [31:0] y, input logic ci,
                           input int gap, input string tag);
        logic [32:0] full;
        res_t r;
        full   = {1'b0, x} + {1'b0, y} + {32'b0, ci};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (x[31] == y[31]) && (full[31] != x[31]);
        sb.push_back(r);
        for (int b = 0; b < 4; b++) begin
            drive_beat(x[8*b +: 8], y[8*b +: 8], ci);
            check({tag, "_valid_timing"}, 64'(out_valid), 64'(b == 3));
            if (b != 3) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("result_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic get_result(input string tag);
        res_t r;
        wait_valid();
        check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check({tag, "_sum"}, 64'(out_sum), 64'(r.sum));
            check({tag, "_cout"}, 64'(out_cout), 64'(r.cout));
            check({tag, "_ovf"}, 64'(out_ovf), 64'(r.ovf));
        end
        check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        res_t r;
        rst = 1'b1;
        out_ready = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom);
            in_x = 8'($urandom);
            in_y = 8'($urandom);
            in_cin = 1'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        send_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, "carry");
        get_result("carry");

        send_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2, "ripple");
        get_result("ripple");

        send_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, "ovf_pos");
        get_result("ovf_pos");
        send_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, "ovf_neg");
        get_result("ovf_neg");

        // Backpressure: result must stay frozen while upstream keeps pushing.
        send_op(32'h1234_5678, 32'h0101_0101, 1'b0, 0, "bp");
        wait_valid();
        r = sb.pop_front();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_x = 8'($urandom);
            in_y = 8'($urandom);
            in_cin = 1'($urandom);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_sum", 64'(out_sum), 64'(r.sum));
            check("bp_cout_ovf", 64'({out_cout, out_ovf}), 64'({r.cout, r.ovf}));
            @(negedge clk);
        end
        in_x = 8'h01;
        in_y = 8'h00;
        in_cin = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        send_op(32'h0000_0001, 32'h0000_0000, 1'b1, 0, "bp_next");
        get_result("bp_next");

        drive_beat(8'h11, 8'h22, 1'b0);
        drive_beat(8'h11, 8'h22, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_sum_cleared", 64'(out_sum), 64'd0);
        send_op(32'h0102_0304, 32'h1020_3040, 1'b0, 0, "midrst");
        get_result("midrst");

        for (int i = 0; i < 4; i++) begin
            send_op($urandom, $urandom, 1'($urandom), i % 2, "rand");
            get_result("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/byte_serial_adder.md
# byte_serial_adder

Multi-byte adder that accepts two wide operands one byte pair per beat, least-significant byte first, over a valid/ready stream. Each beat is added by one `conditional_sum_adder` instance (8-bit x, y, cin -> s, cout), with the carry registered between beats. When the last beat has been added, the block presents the packed sum, carry-out and signed overflow on a valid/ready result port. It sits directly upstream of the adder datapath: it sequences operands into it and assembles what it produces.

## Interface

Parameters:
- NBYTES, default 4: operand width in bytes. Legal range is 2..16. The result width is 8*NBYTES.

Ports:
- clk, input, 1: the single clock. All state updates on the rising edge.
- rst, input, 1: reset. Synchronous and active-high.
- in_valid, input, 1: the upstream beat is valid.
- in_ready, output, 1: the block can accept a beat.
- in_x, input, 8: operand X byte.
- in_y, input, 8: operand Y byte.
- in_cin, input, 1: initial carry-in. Sampled only on beat 0 of an operation.
- out_valid, output, 1: the result is valid.
- out_ready, input, 1: downstream accepts the result.
- out_sum, output, 8*NBYTES: the packed sum. Byte k comes from beat k.
- out_cout, output, 1: carry-out of the most-significant byte.
- out_ovf, output, 1: two's-complement overflow of the full-width add.

## Operation

- Beat transfer: a beat transfers on a rising edge where `in_valid & in_ready` is 1.
- Upstream rule: in_x, in_y and in_cin are held stable while `in_valid & !in_ready`.
- The FSM has two states, ACC and HOLD.
- ACC state:
  - in_ready=1 and out_valid=0.
  - On each transfer, `{c, s} = in_x + in_y + cin_sel`, where cin_sel = in_cin when cnt==0, else carry_q.
  - s is written to out_sum byte [cnt] and c is written to carry_q.
  - If cnt < NBYTES-1: cnt increments and the state stays ACC.
  - If cnt == NBYTES-1:
    - cnt clears to 0 and the state moves to HOLD.
    - out_cout <= c.
    - out_ovf <= (in_x[7] == in_y[7]) && (s[7] != in_x[7]).
- HOLD state:
  - in_ready=0 and out_valid=1.
  - out_sum, out_cout and out_ovf are frozen.
  - When out_ready=1, the state returns to ACC on that edge.
  - Result registers keep their values until they are overwritten by the next operation.
- No bypass: a beat can never be accepted in the same cycle that a result is consumed.
- Gaps in in_valid during ACC are allowed. cnt and carry_q hold across idle cycles.
- out_ready is ignored while in ACC.
- Byte index cnt is $clog2(NBYTES) bits wide and never exceeds NBYTES-1.
- Arithmetic is unsigned modulo 2^(8*NBYTES). out_cout is the unsigned carry. out_ovf is valid for signed interpretation only.

## Timing

- Reset: when rst=1 on an edge, the block enters the following state on that edge, regardless of current state:
  - state=ACC, cnt=0, carry_q=0.
  - out_sum=0, out_cout=0, out_ovf=0, out_valid=0.
  - in_ready=1 from the cycle after reset.
- rst has priority over every other input, including a concurrent transfer or result accept.
- Reset during a partial operation discards all accepted beats. The next transfer is beat 0.
- Latency: out_valid rises on the edge that accepts beat NBYTES-1, so it is high in the next cycle.
- Minimum throughput: one operation per NBYTES+1 cycles. This is NBYTES beat cycles plus at least one HOLD cycle.
- in_ready is a pure function of state (registered), with no combinational path from out_ready.
- out_valid is a pure function of state.
- The adder path is single-cycle combinational: in_x/in_y/carry_q through conditional_sum_adder into registers.

## Test plan

- Reset: apply rst for 2 cycles with random inputs.
  - Required: out_valid=0, out_sum=0, out_cout=0, out_ovf=0 and in_ready=1 after release.
- Carry propagation (NBYTES=4): 0x000000FF + 0x00000001, cin=0, 4 back-to-back beats.
  - Required: out_valid in cycle 5, out_sum=0x00000100, cout=0, ovf=0.
- Full ripple: 0xFFFFFFFF + 0x00000000, cin=1, with 2-cycle in_valid gaps between beats.
  - Required: out_sum=0x00000000, cout=1, ovf=0.
- Signed overflow: 0x7FFFFFFF + 0x00000001, cin=0.
  - Required: out_sum=0x80000000, cout=0, ovf=1.
  - Then 0x80000000 + 0x80000000 -> sum=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after the result, with in_valid held high.
  - Required: in_ready=0 and outputs frozen throughout.
  - After out_ready=1 for one cycle: in_ready=1 next cycle, and the following beat is beat 0 (in_cin sampled).
- Reset mid-operation: accept 2 beats of 0x11111111 + 0x22222222, assert rst for 1 cycle, then send 4 beats of 0x01020304 + 0x10203040.
  - Required: out_sum=0x11223344, with no stale bytes.
